// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and the raw PWM compare for the PWM controller.
// No ports; imported with "import pwm_pkg::*".
package pwm_pkg;

    localparam int unsigned PWM_STEPS = 256;
    localparam int unsigned NUM_CH    = 16;
    localparam int unsigned DUTY_W    = 8;

    localparam logic [DUTY_W-1:0] DUTY_FULL  = 8'hFF;
    localparam logic [DUTY_W-1:0] COUNT_LAST = DUTY_W'(PWM_STEPS - 1);

    // 0xFF is special-cased to full on; a plain compare would leave one step low.
    function automatic logic pwm_raw(input logic [DUTY_W-1:0] count,
                                     input logic [DUTY_W-1:0] duty);
        return (duty == DUTY_FULL) ? 1'b1 : (count < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running divide-by-PRESCALE counter producing a step tick.
// Ports:
//   clk  in  : system clock, rising edge
//   rst  in  : asynchronous reset, active-low
//   clr  in  : synchronous clear of the counter
//   tick out : high while the counter sits at PRESCALE-1
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_pre_cnt;

    assign tick = (r_pre_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre_cnt <= '0;
        end else if (clr || tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// pwm_controller: 16-channel output stage with shared PWM, duty shadowed per period.
// Ports:
//   clk             in     : system clock, rising edge
//   rst             in     : asynchronous reset, active-low
//   ena             in     : block enable; low holds everything idle and cleared
//   en_reg_out_*    in [8] : per-channel output enable
//   en_reg_pwm_*    in [8] : per-channel PWM select (else static on)
//   pwm_duty_cycle  in [8] : requested duty, loaded at each period boundary
//   out             out[16]: registered channel outputs
//   period_start    out    : one-cycle pulse when pwm_count first reads 0
//   pwm_count       out[8] : current PWM step
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [DUTY_W-1:0] pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start,
    output logic [DUTY_W-1:0] pwm_count
);

    logic              w_clr;
    logic              w_tick;
    logic              w_boundary;
    logic              w_raw;
    logic [NUM_CH-1:0] w_en_out;
    logic [NUM_CH-1:0] w_en_pwm;
    logic [NUM_CH-1:0] w_out_d;

    logic [DUTY_W-1:0] r_pwm_count;
    logic [DUTY_W-1:0] r_duty_shadow;
    logic [NUM_CH-1:0] r_out;
    logic              r_period_start;

    assign w_clr = !ena;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    assign w_boundary = w_tick && (r_pwm_count == COUNT_LAST);
    assign w_raw      = pwm_raw(r_pwm_count, r_duty_shadow);
    assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Enabled static channels are 1; enabled PWM channels follow the raw compare.
    always_comb begin
        w_out_d = w_en_out & (~w_en_pwm | {NUM_CH{w_raw}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_count    <= '0;
            r_duty_shadow  <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else if (!ena) begin
            r_pwm_count    <= '0;
            r_duty_shadow  <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_d;
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_pwm_count <= r_pwm_count + 1'b1;
            end
            // A write landing in the boundary cycle itself is captured here.
            if (w_boundary) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
    assign pwm_count    = r_pwm_count;

endmodule

// File: tb/tb_pwm_controller.sv
module tb_pwm_controller;

    localparam int unsigned PRE    = 13;
    localparam int          PERIOD = 256 * PRE;
    localparam int          BOUND  = PERIOD + 600;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_start;
    logic [7:0]  pwm_count;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_controller #(
        .PRESCALE(PRE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (duty),
        .out            (out),
        .period_start   (period_start),
        .pwm_count      (pwm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          phase;   // 0: raw PWM constantly 0, 1: raw PWM constantly 1
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the negedge of a cycle with period_start high.
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            cyc();
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of a period_start cycle; runs to the next one.
    task automatic measure(input bit do_change, output int high, output int len,
                           output int mixed, output int first_hi, output bit ok);
        high = 0; len = 0; mixed = 0; first_hi = -1; ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (out == 16'hFFFF) begin
                high++;
                if (first_hi < 0) first_hi = len;
            end else if (out != 16'h0000) begin
                mixed++;
            end
            if (do_change && pwm_count == 8'd100) duty = 8'hC0;
            len++;
            cyc();
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_table(input int phase);
        foreach (vecs[k]) begin
            if (vecs[k].phase == phase) begin
                set_en(vecs[k].en_out, vecs[k].en_pwm);
                cyc();
                chk($sformatf("table[%0d] out", k), 32'(out), 32'(vecs[k].exp_out));
            end
        end
    endtask

    initial begin
        int  n, bad, high, len, mixed, first_hi;
        bit  ok, seen;

        // raw = 0: out = en_out & ~en_pwm
        vecs[0]  = '{0, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[1]  = '{0, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2]  = '{0, 16'h00FF, 16'h0F0F, 16'h00F0};
        vecs[3]  = '{0, 16'h1234, 16'h00FF, 16'h1200};
        vecs[4]  = '{0, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[5]  = '{0, 16'h8001, 16'h0001, 16'h8000};
        // raw = 1: out = en_out
        vecs[6]  = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[7]  = '{1, 16'h0F0F, 16'hF0F0, 16'h0F0F};
        vecs[8]  = '{1, 16'hA5A5, 16'hFFFF, 16'hA5A5};
        vecs[9]  = '{1, 16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{1, 16'hC003, 16'h4002, 16'hC003};

        // Reset and idle
        rst = 1'b0; ena = 1'b0; duty = 8'h80;
        set_en(16'hFFFF, 16'hFFFF);
        repeat (3) cyc();
        chk("reset out", 32'(out), 32'h0);
        chk("reset pwm_count", 32'(pwm_count), 32'h0);
        chk("reset period_start", 32'(period_start), 32'h0);
        rst = 1'b1;
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (out != 16'h0 || pwm_count != 8'h0) bad++;
            if (period_start) seen = 1'b1;
        end
        chk("idle out/count", 32'(bad), 32'h0);
        chk("idle period_start", 32'(seen), 32'h0);

        // First period after ena rises: shadow is 0, so PWM channels stay low
        ena = 1'b1;
        n = 0; bad = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out != 16'h0) bad++;
            if (period_start) break;
        end
        chk("first period_start cycle", 32'(n), 32'(PERIOD));
        chk("first period out low", 32'(bad), 32'h0);
        chk("count at period_start", 32'(pwm_count), 32'h0);
        chk("out at period_start", 32'(out), 32'h0);

        // 50 % duty
        measure(1'b0, high, len, mixed, first_hi, ok);
        chk("50% timeout", 32'(ok), 32'h1);
        chk("50% length", 32'(len), 32'(PERIOD));
        chk("50% high", 32'(high), 32'd1664);
        chk("50% first high", 32'(first_hi), 32'd1);
        chk("50% mixed", 32'(mixed), 32'h0);

        // Static mode, across a full period
        set_en(16'hA5A5, 16'h0000);
        cyc();
        chk("static one cycle", 32'(out), 32'hA5A5);
        bad = 0;
        for (int i = 0; i < PERIOD + 50; i++) begin
            cyc();
            if (out != 16'hA5A5) bad++;
        end
        chk("static constant", 32'(bad), 32'h0);

        // Duty 0x00
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h00;
        wait_ps(ok);
        chk("duty0 wait", 32'(ok), 32'h1);
        measure(1'b0, high, len, mixed, first_hi, ok);
        chk("duty0 timeout", 32'(ok), 32'h1);
        chk("duty0 high", 32'(high), 32'h0);
        chk("duty0 mixed", 32'(mixed), 32'h0);
        run_table(0);

        // Duty 0xFF
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'hFF;
        wait_ps(ok);
        chk("dutyFF wait", 32'(ok), 32'h1);
        cyc();
        bad = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (out != 16'hFFFF) bad++;
            cyc();
        end
        chk("dutyFF no low cycle", 32'(bad), 32'h0);
        run_table(1);

        // Mid-period duty change 0x40 -> 0xC0 at pwm_count 100
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h40;
        wait_ps(ok);
        chk("mid wait1", 32'(ok), 32'h1);
        wait_ps(ok);
        chk("mid wait2", 32'(ok), 32'h1);
        measure(1'b1, high, len, mixed, first_hi, ok);
        chk("mid cur period high", 32'(high), 32'd832);
        chk("mid cur period len", 32'(len), 32'(PERIOD));
        measure(1'b0, high, len, mixed, first_hi, ok);
        chk("mid next period high", 32'(high), 32'd2496);
        chk("mid next timeout", 32'(ok), 32'h1);

        // Asynchronous reset mid-period
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            cyc();
            if (pwm_count == 8'd37) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach count 37", 32'(ok), 32'h1);
        chk("out before reset", 32'(out), 32'hFFFF);
        #2 rst = 1'b0;
        #1;
        chk("async reset out", 32'(out), 32'h0);
        chk("async reset count", 32'(pwm_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) cyc();
        chk("restart count 0", 32'(pwm_count), 32'h0);
        cyc();
        chk("restart count 1", 32'(pwm_count), 32'h1);
        chk("restart out", 32'(out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_controller.md
# pwm_controller

Generates the 16 user outputs from the five configuration registers written over SPI (output enables, PWM enables, duty cycle). Contains the prescaler, the 8-bit PWM period counter and the duty-cycle shadow register, so duty changes apply only at period boundaries. It sits between the SPI register bank and the chip output pins, entirely in the `clk` domain.

## Interface
- `PRESCALE`, default 13: `clk` cycles per PWM step. Legal range is 1..65535. With a 10 MHz `clk`, one period is 256×13 = 3328 cycles (≈3.0 kHz).
- `clk` in 1: system clock; all state is clocked on its rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `ena` in 1: block enable. Low forces idle (see Operation).
- `en_reg_out_7_0` in 8: output enable, channels 7..0.
- `en_reg_out_15_8` in 8: output enable, channels 15..8.
- `en_reg_pwm_7_0` in 8: PWM mode select, channels 7..0.
- `en_reg_pwm_15_8` in 8: PWM mode select, channels 15..8.
- `pwm_duty_cycle` in 8: requested duty, 0x00..0xFF.
- `out` out 16: registered channel outputs.
- `period_start` out 1: one-cycle pulse in the first cycle of each PWM period.
- `pwm_count` out 8: current step counter, for debug and verification.

## Operation
- **Configuration inputs.** All config inputs are `clk`-domain register outputs, stable between writes. The block samples them every cycle and does not resynchronise them.
- **Prescaler.**
  - `pre_cnt` counts 0..PRESCALE-1, then wraps to 0.
  - `tick` is asserted while `pre_cnt == PRESCALE-1`.
  - With PRESCALE=1, `tick` is high every cycle.
- **Step counter.**
  - `pwm_count` increments on `tick`. It wraps from 255 to 0 with no overflow flag.
- **Period boundary.** On `tick` with `pwm_count == 255`:
  - `pwm_count` goes to 0.
  - `duty_shadow` loads `pwm_duty_cycle`.
  - `period_start` pulses high for exactly one cycle, coincident with `pwm_count` first reading 0.
- **Raw PWM signal** (combinational from `pwm_count` and `duty_shadow`):
  - When `duty_shadow == 0xFF`: constant 1 (full on).
  - Otherwise: `pwm_count < duty_shadow`, an unsigned 8-bit compare.
  - Duty 0x00 gives constant 0.
  - High time per period is `duty×PRESCALE` cycles, except 0xFF, which gives the full 256×PRESCALE.
- **Channel mux** for channel i, with `en_out` = `{en_reg_out_15_8, en_reg_out_7_0}` and `en_pwm` likewise:
  - `en_out[i] = 0` gives 0.
  - `en_out[i] = 1` and `en_pwm[i] = 0` gives 1 (static on).
  - `en_out[i] = 1` and `en_pwm[i] = 1` gives the raw PWM signal.
- **Enable timing.** Enable registers are not shadowed. A change is visible on `out` one cycle later. Only the duty value is period-aligned.
- **Idle (`ena` low).**
  - Synchronously clears `pre_cnt`, `pwm_count`, `duty_shadow`, `out` and `period_start`.
  - When `ena` rises, the first period begins from 0 with `duty_shadow = 0`.
  - The first requested duty therefore takes effect at the end of that first period.
- **Reset values.** While `rst` is low, every register is 0: `out = 16'h0000`, `period_start = 0`, `pwm_count = 0`, `pre_cnt = 0`, `duty_shadow = 0`. Behaviour after release is identical to `ena` rising.

## Timing
- **Output latency.** `out` is registered: one `clk` cycle from a counter, shadow or enable change to the pin.
- **Counter alignment.** `pwm_count` and `period_start` are registers updated in the same edge. `out` reflects the compare on the previous cycle's `pwm_count`.
- **Duty-change latency.** A `pwm_duty_cycle` write lands at the next period boundary. Worst case is 256×PRESCALE cycles. Intermediate writes within one period are discarded; only the last value is used.
- **Write in the boundary cycle.** If `pwm_duty_cycle` changes in the same cycle as the boundary tick, the new value is captured.
- **Reset mid-period.** Asserting `rst` mid-period drops all outputs to 0 asynchronously. There is no glitch-free completion of the period.

## Structure
- **Shared package `pwm_pkg`:**
  - `PWM_STEPS = 256`
  - `NUM_CH = 16`
  - `DUTY_W = 8`
  - `DUTY_FULL = 8'hFF`
- **Sub-module `pwm_prescaler`:**
  - Parameter `PRESCALE`.
  - Ports `clk`, `rst`, `clr` (driven by `!ena`) and output `tick`.
  - Reused by future timer blocks.
- **Top level.** Step counter, shadow register, compare and 16-channel mux stay in `pwm_controller`.

## Test plan
- **Reset and enable.** Assert `rst` with all enables 0xFF and duty 0x80; release; hold `ena` = 0 → `out == 0`, `pwm_count == 0`, no `period_start`. Raise `ena` → first `period_start` at cycle 3328.
- **Static mode.** `en_out = 16'hA5A5`, `en_pwm = 0` → `out == 16'hA5A5` one cycle after the write, constant across periods.
- **50 % duty.** Duty 0x80, all channels PWM, PRESCALE = 13 → from the second period on, each channel is high exactly 1664 cycles per 3328-cycle period, rising one cycle after `period_start`.
- **Duty extremes.** Duty 0x00 → channels constantly 0. Duty 0xFF → channels constantly 1 with no low cycle across two periods.
- **Mid-period duty change.** Duty 0x40 → 0xC0 written at `pwm_count == 100` → the current period keeps 0x40 (832 high cycles); the next period gives 2496 high cycles.
- **Asynchronous reset mid-period.** Drop `rst` at `pwm_count == 37`, off a `clk` edge → `out` goes to 0 immediately; after release, counting restarts from 0.
